apb_mem_responder: RTL and testbench



---
 rtl/apb_mem_pkg.sv | 20 ++
 rtl/apb_mem_ram.sv | 28 ++
 rtl/apb_mem_responder.sv | 171 +++++++++++++++++
 tb/tb_apb_mem_responder.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/apb_mem_pkg.sv
// Shared types and address helpers for the APB memory responder.
package apb_mem_pkg;

   localparam int APB_DATA_W = 32;
   localparam int APB_ADDR_W = 32;

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} apb_mem_state_e;

   // Word index of a byte address; the low two bits select a byte and are dropped.
   function automatic logic [APB_ADDR_W-1:0] word_idx(input logic [APB_ADDR_W-1:0] addr,
                                                      input int unsigned           depth);
      return (addr >> 2) & APB_ADDR_W'(depth - 1);
   endfunction

   function automatic logic addr_oor(input logic [APB_ADDR_W-1:0] addr,
                                     input int unsigned           depth);
      return (addr >> 2) >= APB_ADDR_W'(depth);
   endfunction

endpackage

// File: rtl/apb_mem_ram.sv
// Synchronous word RAM with registered read data, written for block-RAM inference.
module apb_mem_ram #(
   parameter int DEPTH  = 1024,
   parameter int DATA_W = 32,
   parameter int IDX_W  = $clog2(DEPTH)
) (
   input  logic              clk_i,
   input  logic              we_i,
   input  logic [IDX_W-1:0]  waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic              re_i,
   input  logic [IDX_W-1:0]  raddr_i,
   output logic [DATA_W-1:0] rdata_o
);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] rdata_q;

   // NOTE: the array has no reset; clearing it would defeat block-RAM inference.
   // A read hitting the word written on the same edge returns the new data.
   always_ff @(posedge clk_i) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
      if (re_i) rdata_q <= (we_i && (waddr_i == raddr_i)) ? wdata_i : mem_q[raddr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/apb_mem_responder.sv
// APB completer backed by an internal RAM with programmable wait states.
// Define APB_MEM_PSLVERR_EN to flag out-of-range addresses with pslverr_o instead of wrapping.
module apb_mem_responder
   import apb_mem_pkg::*;
#(
   parameter int DEPTH       = 1024,
   parameter int WAIT_STATES = 0,
   parameter bit INIT_ZERO   = 1'b1
) (
   input  logic                  pclk_i,
   input  logic                  prst_i,
   input  logic                  psel_i,
   input  logic                  penable_i,
   input  logic                  pwrite_i,
   input  logic [APB_ADDR_W-1:0] paddr_i,
   input  logic [APB_DATA_W-1:0] pwdata_i,
   output logic [APB_DATA_W-1:0] prdata_o,
   output logic                  pready_o,
   output logic                  pslverr_o,
   output logic [15:0]           xfer_cnt_o
);

   localparam int         IDX_W = $clog2(DEPTH);
   localparam logic [3:0] WS    = 4'(WAIT_STATES);

   apb_mem_state_e        state_q, state_d;
   logic [3:0]            cnt_q, cnt_d;
   logic                  pwrite_q, pwrite_d;
   logic                  err_q, err_d;
   logic                  pready_q, pready_d;
   logic                  pslverr_q, pslverr_d;
   logic                  rd_vld_q, rd_vld_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [APB_DATA_W-1:0] wdata_q, wdata_d;
   logic [15:0]           xfer_cnt_q;

   logic                  setup;
   logic                  setup_oor;
   logic [IDX_W-1:0]      setup_idx;
   logic                  ram_we, ram_re;
   logic [IDX_W-1:0]      ram_raddr;
   logic [APB_DATA_W-1:0] ram_rdata;

   assign setup     = psel_i & ~penable_i;
   assign setup_idx = IDX_W'(word_idx(paddr_i, DEPTH));
`ifdef APB_MEM_PSLVERR_EN
   assign setup_oor = addr_oor(paddr_i, DEPTH);
`else
   assign setup_oor = 1'b0;
`endif

   // NOTE: every output of this block gets a default first so no path infers a latch.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      pwrite_d  = pwrite_q;
      err_d     = err_q;
      idx_d     = idx_q;
      wdata_d   = wdata_q;
      pready_d  = 1'b0;
      pslverr_d = 1'b0;
      rd_vld_d  = 1'b0;
      ram_re    = 1'b0;
      ram_raddr = idx_q;
      unique case (state_q)
         IDLE, DONE: begin
            state_d = IDLE;
            if (setup) begin
               pwrite_d = pwrite_i;
               err_d    = setup_oor;
               idx_d    = setup_idx;
               wdata_d  = pwdata_i;
               cnt_d    = WS;
               // Zero wait states: completion is the first access cycle, so read now.
               if (WAIT_STATES == 0) begin
                  state_d   = DONE;
                  pready_d  = 1'b1;
                  pslverr_d = setup_oor;
                  rd_vld_d  = ~pwrite_i & ~setup_oor;
                  ram_re    = rd_vld_d;
                  ram_raddr = setup_idx;
               end else begin
                  state_d = ACCESS;
               end
            end
         end
         ACCESS: begin
            if (!psel_i) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (penable_i) begin
               if (cnt_q <= 4'd1) begin
                  state_d   = DONE;
                  cnt_d     = '0;
                  pready_d  = 1'b1;
                  pslverr_d = err_q;
                  rd_vld_d  = ~pwrite_q & ~err_q;
                  ram_re    = rd_vld_d;
               end else begin
                  cnt_d = cnt_q - 4'd1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge pclk_i or posedge prst_i) begin
      if (prst_i) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         pwrite_q  <= 1'b0;
         err_q     <= 1'b0;
         pready_q  <= 1'b0;
         pslverr_q <= 1'b0;
         rd_vld_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         pwrite_q  <= pwrite_d;
         err_q     <= err_d;
         pready_q  <= pready_d;
         pslverr_q <= pslverr_d;
         rd_vld_q  <= rd_vld_d;
      end
   end

   // Latched address/data are only consumed under the reset-controlled state.
   always_ff @(posedge pclk_i) begin
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
   end

   if (INIT_ZERO) begin : g_cnt_rst
      always_ff @(posedge pclk_i or posedge prst_i) begin
         if (prst_i)                xfer_cnt_q <= '0;
         else if (state_q == DONE) xfer_cnt_q <= xfer_cnt_q + 16'd1;
      end
   end else begin : g_cnt_free
      always_ff @(posedge pclk_i) begin
         if (state_q == DONE) xfer_cnt_q <= xfer_cnt_q + 16'd1;
      end
   end

   assign ram_we = (state_q == DONE) & pwrite_q & ~err_q;

   apb_mem_ram #(
      .DEPTH  (DEPTH),
      .DATA_W (APB_DATA_W),
      .IDX_W  (IDX_W)
   ) u_ram (
      .clk_i   (pclk_i),
      .we_i    (ram_we),
      .waddr_i (idx_q),
      .wdata_i (wdata_q),
      .re_i    (ram_re),
      .raddr_i (ram_raddr),
      .rdata_o (ram_rdata)
   );

   assign prdata_o   = rd_vld_q ? ram_rdata : '0;
   assign pready_o   = pready_q;
   assign xfer_cnt_o = xfer_cnt_q;
`ifdef APB_MEM_PSLVERR_EN
   assign pslverr_o  = pslverr_q;
`else
   assign pslverr_o  = 1'b0;
`endif

endmodule

// File: tb/tb_apb_mem_responder.sv
// Scoreboard bench: instance 0 has no wait states, instance 1 has three.
module tb_apb_mem_responder;

   localparam int DEPTH = 1024;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [1:0]       psel, penable, pwrite, pready, pslverr;
   logic [1:0][31:0] paddr, pwdata, prdata;
   logic [1:0][15:0] xcnt;

   apb_mem_responder #(.DEPTH(DEPTH), .WAIT_STATES(0), .INIT_ZERO(1'b1)) u_dut0 (
      .pclk_i(clk), .prst_i(rst), .psel_i(psel[0]), .penable_i(penable[0]),
      .pwrite_i(pwrite[0]), .paddr_i(paddr[0]), .pwdata_i(pwdata[0]),
      .prdata_o(prdata[0]), .pready_o(pready[0]), .pslverr_o(pslverr[0]),
      .xfer_cnt_o(xcnt[0])
   );

   apb_mem_responder #(.DEPTH(DEPTH), .WAIT_STATES(3), .INIT_ZERO(1'b1)) u_dut3 (
      .pclk_i(clk), .prst_i(rst), .psel_i(psel[1]), .penable_i(penable[1]),
      .pwrite_i(pwrite[1]), .paddr_i(paddr[1]), .pwdata_i(pwdata[1]),
      .prdata_o(prdata[1]), .pready_o(pready[1]), .pslverr_o(pslverr[1]),
      .xfer_cnt_o(xcnt[1])
   );

   typedef struct {
      logic [31:0] data;
      logic        err;
      logic        wr;
   } exp_t;

   exp_t        sb[$];
   int          n_cmp = 0;
   int          n_err = 0;
   logic [31:0] mdl [2][DEPTH];
   int          mdl_cnt [2];

   function automatic int ws_of(input int d);
      return (d == 0) ? 0 : 3;
   endfunction

   function automatic logic oor(input logic [31:0] a);
      return a[31:12] != 20'h0;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Called at posedge+1; leaves psel/penable high so the caller may go straight to the next setup.
   task automatic apb_xfer(input int d, input logic wr, input logic [31:0] addr, input logic [31:0] data);
      exp_t e;
      int   n;
      logic err_exp;
      err_exp = 1'b0;
`ifdef APB_MEM_PSLVERR_EN
      err_exp = oor(addr);
`endif
      e.wr   = wr;
      e.err  = err_exp;
      e.data = (wr || err_exp) ? 32'h0 : mdl[d][addr[11:2]];
      sb.push_back(e);

      psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr; paddr[d] = addr; pwdata[d] = data;
      @(negedge clk);
      check("setup_ready_low", 32'(pready[d]), 32'h0);
      @(posedge clk); #1;
      penable[d] = 1'b1;
      paddr[d]   = ~addr;
      pwdata[d]  = ~data;
      n = 0;
      forever begin
         @(negedge clk);
         n++;
         if (pready[d] === 1'b1 || n > 20) break;
         @(posedge clk); #1;
      end
      e = sb.pop_front();
      check("ready_latency", 32'(n), 32'(ws_of(d) + 1));
      check("pslverr", 32'(pslverr[d]), 32'(e.err));
      if (!e.wr) check("rdata", prdata[d], e.data);
      if (wr && !err_exp) mdl[d][addr[11:2]] = data;
      mdl_cnt[d]++;
      @(posedge clk); #1;
      check("xfer_cnt", 32'(xcnt[d]), 32'(mdl_cnt[d] & 16'hFFFF));
   endtask

   task automatic bus_idle(input int d);
      psel[d] = 1'b0; penable[d] = 1'b0;
      @(negedge clk);
      check("idle_ready_low", 32'(pready[d]), 32'h0);
      check("idle_rdata_zero", prdata[d], 32'h0);
      @(posedge clk); #1;
   endtask

   task automatic check_zero_outputs(input string tag);
      for (int d = 0; d < 2; d++) begin
         check({tag, "_pready"},  32'(pready[d]),  32'h0);
         check({tag, "_prdata"},  prdata[d],       32'h0);
         check({tag, "_pslverr"}, 32'(pslverr[d]), 32'h0);
         check({tag, "_xcnt"},    32'(xcnt[d]),    32'h0);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded its time budget");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      psel = '0; penable = '0; pwrite = '0; paddr = '0; pwdata = '0;
      mdl_cnt[0] = 0; mdl_cnt[1] = 0;
      @(posedge clk);
      @(negedge clk);
      check_zero_outputs("reset");
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;

      // No wait states: write then immediately read the same word.
      apb_xfer(0, 1'b1, 32'h10, 32'hDEADBEEF);
      apb_xfer(0, 1'b0, 32'h10, 32'h0);
      bus_idle(0);

      // Back-to-back writes then reads, no idle cycles in between.
      apb_xfer(0, 1'b1, 32'h0, 32'h1111_0000);
      apb_xfer(0, 1'b1, 32'h4, 32'h2222_4444);
      apb_xfer(0, 1'b1, 32'h8, 32'h3333_8888);
      apb_xfer(0, 1'b0, 32'h8, 32'h0);
      apb_xfer(0, 1'b0, 32'h4, 32'h0);
      apb_xfer(0, 1'b0, 32'h0, 32'h0);
      bus_idle(0);

      // Out-of-range: wraps onto word 0, or errors and leaves it intact.
      apb_xfer(0, 1'b1, 32'h1000, 32'h7777_7777);
      apb_xfer(0, 1'b0, 32'h0, 32'h0);
      apb_xfer(0, 1'b0, 32'h1000, 32'h0);
      bus_idle(0);

      // Three wait states.
      apb_xfer(1, 1'b1, 32'h0, 32'hA5A5_5A5A);
      bus_idle(1);
      apb_xfer(1, 1'b0, 32'h0, 32'h0);
      bus_idle(1);

      // Abort a write after one wait cycle.
      apb_xfer(1, 1'b1, 32'h20, 32'h1111_1111);
      bus_idle(1);
      psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1; paddr[1] = 32'h20; pwdata[1] = 32'h1234_5678;
      @(posedge clk); #1;
      penable[1] = 1'b1;
      @(negedge clk);
      check("abort_wait_ready", 32'(pready[1]), 32'h0);
      @(posedge clk); #1;
      psel[1] = 1'b0; penable[1] = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("abort_ready_low", 32'(pready[1]), 32'h0);
      end
      check("abort_xfer_cnt", 32'(xcnt[1]), 32'(mdl_cnt[1]));
      @(posedge clk); #1;
      apb_xfer(1, 1'b0, 32'h20, 32'h0);
      bus_idle(1);

      // Reset during a wait cycle of a write.
      apb_xfer(1, 1'b1, 32'h40, 32'h0BAD_F00D);
      bus_idle(1);
      psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1; paddr[1] = 32'h40; pwdata[1] = 32'hCAFE_F00D;
      @(posedge clk); #1;
      penable[1] = 1'b1;
      @(negedge clk); #1;
      rst = 1'b1;
      #1;
      check_zero_outputs("async_reset");
      mdl_cnt[0] = 0; mdl_cnt[1] = 0;
      psel[1] = 1'b0; penable[1] = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      bus_idle(1);
      apb_xfer(1, 1'b0, 32'h40, 32'h0);
      bus_idle(1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
